// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor in the free-running refclk domain.
// It pulses the PLL reset, waits for lock with bounded retries, and holds sys_rst_n until lock is stable.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 50,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_fail,
  output logic [7:0] lock_lost_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRIES);

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [7:0]             retry;
  logic [7:0]             retry_nxt;
  logic [7:0]             lost_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    lost_nxt  = lock_lost_cnt;
    case (state)
      ST_PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock seen on the timeout cycle wins over the retry/fail decision.
        if (lock_s) begin
          state_nxt = ST_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry == RETRY_MAX) begin
            state_nxt = ST_FAIL;
          end else begin
            retry_nxt = retry + 8'd1;
            state_nxt = ST_PLL_RST;
          end
        end
      end
      ST_STABLE: begin
        // A dropout is a glitch: back to waiting without consuming a retry.
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          retry_nxt = 8'd0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_PLL_RST;
          if (lock_lost_cnt != 8'hff) lost_nxt = lock_lost_cnt + 8'd1;
        end
      end
      ST_FAIL:  state_nxt = ST_FAIL;
      default:  state_nxt = ST_PLL_RST;
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as the state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      state         <= ST_PLL_RST;
      cnt           <= '0;
      retry         <= 8'd0;
      lock_lost_cnt <= 8'd0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      pll_fail      <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state         <= state_nxt;
      retry         <= retry_nxt;
      lock_lost_cnt <= lost_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + CNT_W'(1);
      end
      pll_rst   <= (state_nxt == ST_PLL_RST);
      sys_rst_n <= (state_nxt == ST_RUN);
      pll_fail  <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a phase/deadline model checked every cycle,
// plus literal edge numbers for lock, timeout, glitch, loss, late-lock and reset scenarios.
module tb_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int LTO = 20;
  localparam int LSC = 8;
  localparam int MR  = 2;
  localparam int SS  = 2;

  localparam int P_PULSE  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  // ---------------- clock / reset ----------------
  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       pll_fail;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state_dbg;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .SYNC_STAGES(SS),
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT_CYCLES(LTO),
    .LOCK_STABLE_CYCLES(LSC),
    .MAX_RETRIES(MR),
    .CNT_W(20)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .pll_fail(pll_fail),
    .lock_lost_cnt(lock_lost_cnt),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase plus the edge it was entered on; deadlines are measured as elapsed edges.
  int          m_ph = P_PULSE;
  int          m_start = 0;
  int          m_edge = 0;
  int          m_retry = 0;
  int          m_lost = 0;
  logic [SS-1:0] m_seen = '0;

  initial begin
    logic ls;
    int   el;
    forever begin
      @(posedge refclk or negedge rst_n);
      if (!rst_n) begin
        m_ph = P_PULSE; m_start = 0; m_edge = 0; m_retry = 0; m_lost = 0; m_seen = '0;
      end else begin
        ls     = m_seen[SS-1];
        m_seen = {m_seen[SS-2:0], pll_locked};
        m_edge = m_edge + 1;
        el     = m_edge - m_start;
        case (m_ph)
          P_PULSE:  if (el == PRC) begin m_ph = P_WAIT; m_start = m_edge; end
          P_WAIT: begin
            if (ls) begin
              m_ph = P_STABLE; m_start = m_edge;
            end else if (el == LTO) begin
              if (m_retry == MR) m_ph = P_FAIL;
              else begin m_retry++; m_ph = P_PULSE; end
              m_start = m_edge;
            end
          end
          P_STABLE: begin
            if (!ls) begin
              m_ph = P_WAIT; m_start = m_edge;
            end else if (el == LSC) begin
              m_ph = P_RUN; m_start = m_edge; m_retry = 0;
            end
          end
          P_RUN: begin
            if (!ls) begin
              m_ph = P_PULSE; m_start = m_edge;
              if (m_lost < 255) m_lost++;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- scoreboard / event trackers ----------------
  logic prev_sys, prev_pll, prev_fail;
  int   pulses, rise_edge, pll_fall, sys_rise, run_exit, fail_edge, pw_min, pw_max;
  logic sys_ever;

  initial begin
    int w;
    forever begin
      @(negedge refclk);
      check("pll_rst", pll_rst, m_ph == P_PULSE);
      check("sys_rst_n", sys_rst_n, m_ph == P_RUN);
      check("pll_fail", pll_fail, m_ph == P_FAIL);
      check("lock_lost_cnt", lock_lost_cnt, m_lost);
      if (!rst_n) begin
        prev_sys = 0; prev_pll = 1; prev_fail = 0; pulses = 1; rise_edge = 0;
        pll_fall = -1; sys_rise = -1; run_exit = -1; fail_edge = -1;
        pw_min = 999; pw_max = 0; sys_ever = 0;
      end else begin
        if (pll_rst && !prev_pll) begin pulses++; rise_edge = m_edge; end
        if (!pll_rst && prev_pll) begin
          w = m_edge - rise_edge;
          if (w < pw_min) pw_min = w;
          if (w > pw_max) pw_max = w;
          if (pll_fall < 0) pll_fall = m_edge;
        end
        if (sys_rst_n && !prev_sys) begin sys_rise = m_edge; sys_ever = 1; end
        if (!sys_rst_n && prev_sys) run_exit = m_edge;
        if (pll_fail && !prev_fail) fail_edge = m_edge;
        prev_sys = sys_rst_n; prev_pll = pll_rst; prev_fail = pll_fail;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  // Assert reset between edges and confirm outputs settle with no refclk edge.
  task automatic reset_check(input string tag);
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_pll_rst"}, pll_rst, 1);
    check({tag, "_rst_sys_rst_n"}, sys_rst_n, 0);
    check({tag, "_rst_pll_fail"}, pll_fail, 0);
    check({tag, "_rst_lost"}, lock_lost_cnt, 0);
  endtask

  // Release reset two edges later; the next posedge is edge 1.
  task automatic release_reset(input logic locked);
    pll_locked = locked;
    repeat (2) @(posedge refclk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_sys(input string name, input logic val, input int max);
    int i = 0;
    while (sys_rst_n !== val && i < max) begin wait_edges(1); i++; end
    check(name, sys_rst_n, val);
  endtask

  task automatic wait_pll_rst(input string name, input int max);
    int i = 0;
    while (pll_rst !== 1'b1 && i < max) begin wait_edges(1); i++; end
    check(name, pll_rst, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Clean lock
    release_reset(1'b1);
    wait_edges(20);
    check("clean_pll_fall_edge", pll_fall, 4);
    check("clean_pulse_width", pw_max, PRC);
    check("clean_sys_rise_edge", sys_rise, 13);
    check("clean_pulses", pulses, 1);
    check("clean_sys_high", sys_rst_n, 1);
    check("clean_fail_low", pll_fail, 0);

    // Never lock
    reset_check("run");
    release_reset(1'b0);
    wait_edges(80);
    check("never_fail_edge", fail_edge, 72);
    check("never_pulses", pulses, 3);
    check("never_pw_min", pw_min, PRC);
    check("never_pw_max", pw_max, PRC);
    check("never_sys_ever", sys_ever, 0);
    check("never_fail_high", pll_fail, 1);

    // One-cycle glitch during STABLE
    reset_check("fail");
    release_reset(1'b1);
    wait_edges(7);
    pll_locked = 1'b0;
    wait_edges(1);
    pll_locked = 1'b1;
    wait_edges(15);
    check("glitch_sys_rise_edge", sys_rise, 19);
    check("glitch_pulses", pulses, 1);

    // Lock loss in RUN, then re-lock
    reset_check("glitch");
    release_reset(1'b1);
    wait_edges(20);
    pll_locked = 1'b0;
    wait_edges(5);
    pll_locked = 1'b1;
    wait_edges(15);
    check("loss_run_exit_edge", run_exit, 23);
    check("loss_lost_cnt", lock_lost_cnt, 1);
    check("loss_pulses", pulses, 2);
    check("loss_relock_rise_edge", sys_rise, 36);
    reset_check("run_after_loss");

    // Reset while in STABLE
    release_reset(1'b1);
    wait_edges(8);
    reset_check("stable");

    // Late lock during attempt 2, then loss with never-lock: retries must be fresh
    release_reset(1'b0);
    wait_edges(35);
    pll_locked = 1'b1;
    wait_edges(14);
    check("late_sys_rise_edge", sys_rise, 46);
    check("late_pulses", pulses, 2);
    pll_locked = 1'b0;
    wait_edges(80);
    check("late_run_exit_edge", run_exit, 52);
    check("late_fail_edge", fail_edge, 124);
    check("late_pulses_total", pulses, 5);
    reset_check("fail_after_late");

    // Saturating lock-loss counter
    release_reset(1'b1);
    for (int k = 0; k < 257; k++) begin
      wait_sys("sat_release", 1'b1, 40);
      if (sys_rst_n !== 1'b1) break;
      pll_locked = 1'b0;
      wait_pll_rst("sat_loss", 10);
      pll_locked = 1'b1;
    end
    wait_edges(3);
    check("sat_lost_cnt", lock_lost_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before t=2000000");
    $fatal(1, "watchdog");
  end

endmodule
